// File: rtl/serial_add_unit.sv
// Bit-serial two's complement adder/subtractor: one operand pair per handshake,
// one bit per clock LSB-first, result held until the consumer takes it.
module serial_add_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic             msb_a;
    logic             msb_b;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-2:0] partial;

    logic             bit_sum;
    logic             carry_next;
    logic [WIDTH-1:0] result_next;

    // Full-adder slice; the final bit completes result_next for capture into sum.
    assign bit_sum     = sa[0] ^ sb[0] ^ carry;
    assign carry_next  = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    assign result_next = {bit_sum, partial};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (idx == LAST_IDX) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is folded in at load time: B is inverted and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa       <= '0;
            sb       <= '0;
            carry    <= 1'b0;
            msb_a    <= 1'b0;
            msb_b    <= 1'b0;
            idx      <= '0;
            partial  <= '0;
            sum      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa      <= a;
                        sb      <= op_sub ? ~b : b;
                        carry   <= op_sub;
                        msb_a   <= a[WIDTH-1];
                        msb_b   <= op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        idx     <= '0;
                        partial <= '0;
                    end
                end
                BUSY: begin
                    sa      <= sa >> 1;
                    sb      <= sb >> 1;
                    carry   <= carry_next;
                    partial <= result_next[WIDTH-1:1];
                    if (idx == LAST_IDX) begin
                        idx      <= '0;
                        sum      <= {carry_next, result_next};
                        overflow <= (msb_a == msb_b) && (bit_sum != msb_a);
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit with an arithmetic reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_serial_add_unit;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] model_sum(input int ua, input int ub, input bit sub);
        int mask;
        int eb;
        mask = (1 << WIDTH) - 1;
        eb   = sub ? (~ub & mask) : ub;
        return (WIDTH+1)'(ua + eb + (sub ? 1 : 0));
    endfunction

    function automatic logic model_ovf(input int ua, input int ub, input bit sub);
        int sa_v;
        int sb_v;
        int r;
        sa_v = (ua >= (1 << (WIDTH-1))) ? ua - (1 << WIDTH) : ua;
        sb_v = (ub >= (1 << (WIDTH-1))) ? ub - (1 << WIDTH) : ub;
        r    = sub ? sa_v - sb_v : sa_v + sb_v;
        return (r > (1 << (WIDTH-1)) - 1) || (r < -(1 << (WIDTH-1)));
    endfunction

    // Transaction-level model: accept in idle, result appears WIDTH edges later.
    bit             m_idle = 1'b1;
    bit             m_done = 1'b0;
    int             m_left = 0;
    logic [WIDTH:0] m_sum  = '0;
    logic           m_ovf  = 1'b0;
    logic [WIDTH:0] m_pend_sum = '0;
    logic           m_pend_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_left <= 0;
            m_sum  <= '0;
            m_ovf  <= 1'b0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_pend_sum <= model_sum(int'(a), int'(b), op_sub);
                m_pend_ovf <= model_ovf(int'(a), int'(b), op_sub);
                m_idle     <= 1'b0;
                m_left     <= WIDTH;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_sum  <= m_pend_sum;
                m_ovf  <= m_pend_ovf;
            end
        end else if (m_done && out_ready) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    always @(negedge clk) begin
        check_val("cmp_in_ready", in_ready, m_idle);
        check_val("cmp_out_valid", out_valid, m_done);
        check_val("cmp_sum", sum, m_sum);
        check_val("cmp_overflow", overflow, m_ovf);
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb, input logic sub);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 32'd0, 32'd1);
        end
        a        = pa;
        b        = pb;
        op_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_val("done_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH:0] exp_sum, input logic exp_ovf);
        check_val({name, "_sum"}, sum, exp_sum);
        check_val({name, "_ovf"}, overflow, exp_ovf);
        check_val({name, "_model_sum"}, m_sum, exp_sum);
        check_val({name, "_model_ovf"}, m_ovf, exp_ovf);
    endtask

    task automatic release_result();
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        check_val("release_in_ready", in_ready, 1'b1);
        check_val("release_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        int lat;
        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #3;
        check_val("reset_in_ready", in_ready, 1'b1);
        check_val("reset_out_valid", out_valid, 1'b0);
        check_val("reset_sum", sum, 5'b00000);
        check_val("reset_overflow", overflow, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;

        $display("[TB] scenario 1: 7 + 1");
        applyStimulus(4'b0111, 4'b0001, 1'b0);
        wait_done(lat);
        check_val("t1_latency", lat, WIDTH + 1);
        checkOutput("t1", 5'b01000, 1'b1);
        release_result();

        $display("[TB] scenario 2: -1 + 1 with out_ready held high");
        out_ready = 1'b1;
        applyStimulus(4'b1111, 4'b0001, 1'b0);
        wait_done(lat);
        checkOutput("t2", 5'b10000, 1'b0);
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        check_val("t2_back_idle", in_ready, 1'b1);

        $display("[TB] scenario 3: subtraction");
        applyStimulus(4'b0011, 4'b0101, 1'b1);
        wait_done(lat);
        checkOutput("t3a", 5'b01110, 1'b0);
        release_result();
        applyStimulus(4'b1000, 4'b0001, 1'b1);
        wait_done(lat);
        checkOutput("t3b", 5'b10111, 1'b1);
        release_result();

        $display("[TB] scenario 4: backpressure");
        applyStimulus(4'b0111, 4'b0001, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            a        = 4'b0011;
            b        = 4'b0011;
            in_valid = 1'b1;
            @(negedge clk);
            check_val("t4_hold_valid", out_valid, 1'b1);
            check_val("t4_hold_sum", sum, 5'b01000);
            check_val("t4_hold_in_ready", in_ready, 1'b0);
        end
        release_result();

        $display("[TB] scenario 5: in_valid during busy");
        applyStimulus(4'b0111, 4'b0001, 1'b0);
        a        = 4'b0101;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        wait_done(lat);
        checkOutput("t5", 5'b01000, 1'b1);
        release_result();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("t5_no_second", out_valid, 1'b0);
        end

        $display("[TB] scenario 6: reset mid-operation");
        @(posedge clk);
        #2;
        applyStimulus(4'b0111, 4'b0001, 1'b0);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 4'b0101;
        b        = 4'b0101;
        #1;
        check_val("t6_rst_in_ready", in_ready, 1'b1);
        check_val("t6_rst_out_valid", out_valid, 1'b0);
        check_val("t6_rst_sum", sum, 5'b00000);
        check_val("t6_rst_ovf", overflow, 1'b0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            check_val("t6_no_out_valid", out_valid, 1'b0);
            check_val("t6_idle", in_ready, 1'b1);
        end
        @(posedge clk);
        #2;
        applyStimulus(4'b0010, 4'b0011, 1'b0);
        wait_done(lat);
        checkOutput("t6", 5'b00101, 1'b0);
        release_result();

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
